// File: rtl/systolic_controller_if.sv
// systolic_controller_if: weight/config, vector stream, array and status signals of the sequencer
interface systolic_controller_if #(
    parameter int N     = 2,
    parameter int CNT_W = 8
);
    logic               cfg_weight_valid;
    logic               cfg_weight_ready;
    logic [8*N*N-1:0]   cfg_weight;
    logic               start;
    logic [CNT_W-1:0]   vec_count;
    logic               in_valid;
    logic               in_ready;
    logic [8*N-1:0]     in_data;
    logic [8*N-1:0]     sa_datain;
    logic [8*N*N-1:0]   sa_weightin;
    logic [8*N-1:0]     sa_macout;
    logic               out_valid;
    logic [8*N-1:0]     out_data;
    logic               busy;
    logic               done;

    modport slave (
        input  cfg_weight_valid, cfg_weight, start, vec_count, in_valid, in_data, sa_macout,
        output cfg_weight_ready, in_ready, sa_datain, sa_weightin, out_valid, out_data, busy, done
    );

    modport master (
        output cfg_weight_valid, cfg_weight, start, vec_count, in_valid, in_data, sa_macout,
        input  cfg_weight_ready, in_ready, sa_datain, sa_weightin, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/systolic_controller.sv
// systolic_controller: weight-stationary array sequencer with input skew, output deskew and job control
module systolic_controller #(
    parameter int ARRAY_SIZE = 2,
    parameter int PIPE_LAT   = 2,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_controller_if.slave bus
);
    localparam int N = ARRAY_SIZE;
    localparam int L = PIPE_LAT + N + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [8*N*N-1:0] w_q;
    logic             loaded_q;
    logic [CNT_W-1:0] vec_q, cnt_q;
    logic [L-1:0]     tok_q;
    logic [8*N-1:0]   out_q, aligned;
    logic             load_w, go, acc;

    assign load_w = (state_q == S_IDLE) && bus.cfg_weight_valid;
    assign go     = (state_q == S_IDLE) && bus.start && loaded_q && !bus.cfg_weight_valid;
    assign acc    = (state_q == S_RUN) && bus.in_valid;

    assign bus.sa_weightin = w_q;
    assign bus.out_data    = out_q;
    assign bus.out_valid   = tok_q[L-1];

    // Next state and status outputs; DRAIN ends once only the emerging token remains
    always_comb begin
        state_d              = state_q;
        bus.cfg_weight_ready = (state_q == S_IDLE);
        bus.in_ready         = (state_q == S_RUN);
        bus.busy             = (state_q != S_IDLE);
        bus.done             = (state_q == S_DONE);
        case (state_q)
            S_IDLE:  if (go) state_d = (bus.vec_count == '0) ? S_DONE : S_RUN;
            S_RUN:   if (acc && (cnt_q + CNT_W'(1) == vec_q)) state_d = S_DRAIN;
            S_DRAIN: if (!(|tok_q[L-2:0])) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Weight tile is only writable in IDLE, so it is stable while tokens fly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q      <= '0;
            loaded_q <= 1'b0;
        end else if (load_w) begin
            w_q      <= bus.cfg_weight;
            loaded_q <= 1'b1;
        end
    end

    // Job length latch and accept counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_q <= '0;
            cnt_q <= '0;
        end else if (go) begin
            vec_q <= bus.vec_count;
            cnt_q <= '0;
        end else if (acc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Token pipe: one bit per accept, emerges aligned with its result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tok_q <= '0;
        else       tok_q <= {tok_q[L-2:0], acc};
    end

    // Result register, loaded one cycle before its token reaches out_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           out_q <= '0;
        else if (tok_q[L-2]) out_q <= aligned;
    end

    for (genvar r = 0; r < N; r++) begin : g_skew
        logic [7:0] sk_q [r+1];
        // Row r delay line of r+1 stages; non-accept cycles inject zero bubbles
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k <= r; k++) sk_q[k] <= '0;
            end else begin
                sk_q[0] <= acc ? bus.in_data[r*8 +: 8] : 8'd0;
                for (int k = 1; k <= r; k++) sk_q[k] <= sk_q[k-1];
            end
        end
        assign bus.sa_datain[r*8 +: 8] = sk_q[r];
    end

    for (genvar c = 0; c < N; c++) begin : g_deskew
        localparam int D = N - 1 - c;
        if (D == 0) begin : g_pass
            assign aligned[c*8 +: 8] = bus.sa_macout[c*8 +: 8];
        end else begin : g_dly
            logic [7:0] dk_q [D];
            // Column c delayed so that earlier columns wait for the last one
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < D; k++) dk_q[k] <= '0;
                end else begin
                    dk_q[0] <= bus.sa_macout[c*8 +: 8];
                    for (int k = 1; k < D; k++) dk_q[k] <= dk_q[k-1];
                end
            end
            assign aligned[c*8 +: 8] = dk_q[D-1];
        end
    end
endmodule

// File: tb/tb_systolic_controller.sv
// tb_systolic_controller: directed checks of the sequencer against a behavioural 2x2 array
module tb_systolic_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic seen;

    localparam logic [31:0] W1 = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] W2 = {8'd3, 8'd0, 8'd0, 8'd2};

    always #5 clk = ~clk;

    systolic_controller_if #(.N(2), .CNT_W(8)) bus ();

    systolic_controller #(.ARRAY_SIZE(2), .PIPE_LAT(2), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] h1, h2, h3;
    logic [31:0] w;
    logic [7:0]  m0, m1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h1 <= '0;
            h2 <= '0;
            h3 <= '0;
        end else begin
            h1 <= bus.sa_datain;
            h2 <= h1;
            h3 <= h2;
        end
    end

    assign w = bus.sa_weightin;
    assign m0 = h2[7:0] * w[7:0] + h1[15:8] * w[23:16];
    assign m1 = h3[7:0] * w[15:8] + h2[15:8] * w[31:24];
    assign bus.sa_macout = {m1, m0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y);
        tick(1); bus.start = 1'b1; bus.vec_count = 8'd1;
        tick(1); bus.start = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1; bus.in_data = x;
        tick(1); bus.in_valid = 1'b0;
        chk({tag, "_rdy_drop"}, 32'(bus.in_ready), 0);
        chk({tag, "_skew0"}, 32'(bus.sa_datain), {24'd0, x[7:0]});
        tick(1);
        chk({tag, "_skew1"}, 32'(bus.sa_datain), {16'd0, x[15:8], 8'd0});
        tick(2);
        chk({tag, "_ov_early"}, 32'(bus.out_valid), 0);
        tick(1);
        chk({tag, "_ov"}, 32'(bus.out_valid), 1);
        chk({tag, "_y"}, 32'(bus.out_data), 32'(y));
        chk({tag, "_done_early"}, 32'(bus.done), 0);
        tick(1);
        chk({tag, "_ov_end"}, 32'(bus.out_valid), 0);
        chk({tag, "_done"}, 32'(bus.done), 1);
        chk({tag, "_y_hold"}, 32'(bus.out_data), 32'(y));
        tick(1);
        chk({tag, "_done_off"}, 32'(bus.done), 0);
        chk({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        bus.cfg_weight_valid = 1'b0;
        bus.cfg_weight = '0;
        bus.start = 1'b0;
        bus.vec_count = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_wrdy", 32'(bus.cfg_weight_ready), 1);
        chk("rst_irdy", 32'(bus.in_ready), 0);
        chk("rst_ov", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_od", 32'(bus.out_data), 0);
        chk("rst_sad", 32'(bus.sa_datain), 0);
        chk("rst_w", bus.sa_weightin, 0);
        tick(1); reset = 1'b0;

        // Test 1 and 2: single-vector jobs with W1
        tick(1); bus.cfg_weight_valid = 1'b1; bus.cfg_weight = W1;
        tick(1); bus.cfg_weight_valid = 1'b0;
        chk("t1_w", bus.sa_weightin, W1);
        run_one("t1", 16'h0605, 16'h2217);
        run_one("t2", 16'h6464, 16'h5890);

        // Test 3: three back-to-back vectors
        tick(1); bus.start = 1'b1; bus.vec_count = 8'd3;
        tick(1); bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0001;
        tick(1); chk("t3_rdy1", 32'(bus.in_ready), 1); bus.in_data = 16'h0100;
        tick(1); chk("t3_rdy2", 32'(bus.in_ready), 1); bus.in_data = 16'h0101;
        tick(1); bus.in_valid = 1'b0; chk("t3_rdy_drop", 32'(bus.in_ready), 0);
        tick(1); chk("t3_ov_early", 32'(bus.out_valid), 0);
        tick(1); chk("t3_ov0", 32'(bus.out_valid), 1); chk("t3_y0", 32'(bus.out_data), 32'h0201);
        tick(1); chk("t3_ov1", 32'(bus.out_valid), 1); chk("t3_y1", 32'(bus.out_data), 32'h0403);
        tick(1); chk("t3_ov2", 32'(bus.out_valid), 1); chk("t3_y2", 32'(bus.out_data), 32'h0604);
        tick(1); chk("t3_ov_end", 32'(bus.out_valid), 0); chk("t3_done", 32'(bus.done), 1);
        tick(1); chk("t3_idle", 32'(bus.busy), 0);

        // Test 4: bubble between two vectors
        tick(1); bus.start = 1'b1; bus.vec_count = 8'd2;
        tick(1); bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0605;
        tick(1); bus.in_valid = 1'b0; chk("t4_rdy_gap", 32'(bus.in_ready), 1);
        tick(1); bus.in_valid = 1'b1; bus.in_data = 16'h6464;
        tick(1); bus.in_valid = 1'b0; chk("t4_rdy_drop", 32'(bus.in_ready), 0);
        tick(2); chk("t4_ov0", 32'(bus.out_valid), 1); chk("t4_y0", 32'(bus.out_data), 32'h2217);
        tick(1); chk("t4_gap", 32'(bus.out_valid), 0); chk("t4_hold", 32'(bus.out_data), 32'h2217);
        tick(1); chk("t4_ov1", 32'(bus.out_valid), 1); chk("t4_y1", 32'(bus.out_data), 32'h5890);
        chk("t4_done_early", 32'(bus.done), 0);
        tick(1); chk("t4_done", 32'(bus.done), 1);
        tick(1); chk("t4_idle", 32'(bus.busy), 0);

        // Test 6: reset two cycles into a three-vector job
        tick(1); bus.start = 1'b1; bus.vec_count = 8'd3;
        tick(1); bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0001;
        tick(1); bus.in_data = 16'h0100;
        tick(1); bus.in_valid = 1'b0; reset = 1'b1;
        #1;
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_irdy", 32'(bus.in_ready), 0);
        chk("t6_ov", 32'(bus.out_valid), 0);
        chk("t6_od", 32'(bus.out_data), 0);
        chk("t6_sad", 32'(bus.sa_datain), 0);
        chk("t6_w", bus.sa_weightin, 0);
        chk("t6_wrdy", 32'(bus.cfg_weight_ready), 1);
        tick(1); reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen = seen | bus.out_valid | bus.done | bus.busy;
        end
        chk("t6_quiet", 32'(seen), 0);

        // Test 5: start without weights, weight load beats start, empty job
        tick(1); bus.start = 1'b1; bus.vec_count = 8'd1;
        tick(1); bus.start = 1'b0; chk("t5_nowt", 32'(bus.busy), 0);
        bus.cfg_weight_valid = 1'b1; bus.cfg_weight = W2; bus.start = 1'b1;
        tick(1); bus.cfg_weight_valid = 1'b0; bus.start = 1'b0;
        chk("t5_collide", 32'(bus.busy), 0);
        chk("t5_w", bus.sa_weightin, W2);
        bus.start = 1'b1; bus.vec_count = 8'd0;
        tick(1); bus.start = 1'b0;
        chk("t5_zdone", 32'(bus.done), 1);
        chk("t5_zov", 32'(bus.out_valid), 0);
        tick(1);
        chk("t5_zdone_off", 32'(bus.done), 0);
        chk("t5_zidle", 32'(bus.busy), 0);
        run_one("t5", 16'h0907, 16'h1B0E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
